// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one shared UART transmitter.
// One pending byte is accepted per frame and sent as start, DATA_W data bits (LSB first), stop.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  logic [DATA_W-1:0]   req_bytes [NUM_REQ];
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;
  logic                baud_tc;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Search from ptr_q upward, wrapping, for the first pending requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign baud_tc = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          shift_d = req_bytes[win_idx];
          grant_d = win_idx;
          ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter; a round-robin queue model
// predicts each winner and the expected waveform of every frame.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int CPB   = 16;
  localparam int FRAME = (DW + 2) * CPB;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_out;
  logic            busy;
  logic [1:0]      grant_idx;

  logic [NR-1:0]   valid_r;
  logic [DW-1:0]   data_r [NR];
  int              mptr;
  int              checks = 0;
  int              errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  assign req_valid = valid_r;
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = data_r[i];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: scan pending requesters circularly from the model pointer.
  function automatic int model_winner();
    for (int k = 0; k < NR; k++) begin
      if (valid_r[(mptr + k) % NR]) return (mptr + k) % NR;
    end
    return -1;
  endfunction

  // Wait (bounded) for an accept, then check the whole frame cycle by cycle.
  task automatic serve(input int exp_idx, input int max_wait, input bit keep,
                       input logic [NR-1:0] set_m, input logic [NR-1:0] clr_m);
    int n;
    int w;
    int exp_g;
    logic [DW-1:0] b;
    logic exp_tx;
    #1;
    n = 0;
    while (req_ready === '0 && n < max_wait) begin
      @(negedge clk); #1;
      n++;
    end
    w = model_winner();
    check("ready_onehot", 32'(req_ready), (w < 0) ? 32'd0 : 32'(1 << w));
    if (w < 0 || req_ready === '0) return;
    exp_g = (exp_idx >= 0) ? exp_idx : w;
    b = data_r[w];
    @(posedge clk);
    mptr = (w + 1) % NR;
    for (int c = 0; c <= FRAME; c++) begin
      @(negedge clk);
      if (c == FRAME) begin
        check("frame_end_busy", 32'(busy), 32'd0);
        check("frame_end_tx", 32'(tx_out), 32'd1);
      end else begin
        if (c < CPB) exp_tx = 1'b0;
        else if (c < CPB * (DW + 1)) exp_tx = b[(c - CPB) / CPB];
        else exp_tx = 1'b1;
        check("tx_bit", 32'(tx_out), 32'(exp_tx));
        check("busy_frame", 32'(busy), 32'd1);
        check("ready_busy", 32'(req_ready), 32'd0);
        if (c == 0) check("grant_idx", 32'(grant_idx), 32'(exp_g));
        if (c == 0 && !keep) valid_r[w] = 1'b0;
        if (c == 3 && keep) data_r[w] = DW'($urandom);
        if (c == 5) valid_r = valid_r | set_m;
        if (c == 80) valid_r = valid_r & ~clr_m;
      end
    end
    $display("frame: req %0d byte %02h accepted", w, b);
  endtask

  initial begin
    valid_r = '0;
    mptr = 0;
    for (int i = 0; i < NR; i++) data_r[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx_out), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(req_ready), 32'd0);
    end

    // Single requester 2 with 0xA5.
    data_r[2] = 8'hA5;
    valid_r = 4'b0100;
    serve(2, 10, 1'b0, '0, '0);

    // Reset in the middle of a data bit aborts the frame at once.
    data_r[2] = DW'($urandom);
    valid_r = 4'b0100;
    #1;
    check("pre_rst_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    repeat (40) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_out), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    valid_r = '0;
    mptr = 0;
    @(negedge clk);
    rst = 1'b0;

    // All four pending after reset: served 0,1,2,3 back to back.
    for (int i = 0; i < NR; i++) data_r[i] = DW'(8'h10 + i);
    valid_r = 4'b1111;
    serve(0, 5, 1'b0, '0, '0);
    serve(1, 0, 1'b0, '0, '0);
    serve(2, 0, 1'b0, '0, '0);
    serve(3, 0, 1'b0, '0, '0);

    // Move pointer to 2, then 1 and 3 pending: 3 first, then wrap to 1.
    data_r[1] = DW'($urandom);
    valid_r = 4'b0010;
    serve(1, 5, 1'b0, '0, '0);
    data_r[1] = DW'($urandom);
    data_r[3] = DW'($urandom);
    valid_r = 4'b1010;
    serve(3, 5, 1'b0, '0, '0);
    serve(1, 0, 1'b0, '0, '0);

    // Requester 0 appears then withdraws while 1 transmits; never granted.
    data_r[1] = DW'($urandom);
    data_r[0] = DW'($urandom);
    valid_r = 4'b0010;
    serve(1, 5, 1'b0, 4'b0001, 4'b0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("dropped_ready", 32'(req_ready), 32'd0);
    end
    valid_r = 4'b0001;
    serve(0, 5, 1'b0, '0, '0);

    // Data changed mid-frame, then the same requester sends again back to back.
    data_r[2] = DW'($urandom);
    valid_r = 4'b0100;
    serve(2, 5, 1'b1, '0, '0);
    serve(2, 0, 1'b0, '0, '0);

    // Randomized traffic against the model.
    for (int it = 0; it < 14; it++) begin
      logic [NR-1:0] add_m;
      add_m = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++)
        if (!valid_r[i]) data_r[i] = DW'($urandom);
      valid_r = valid_r | add_m;
      serve(-1, 5, 1'($urandom_range(0, 1)), NR'($urandom_range(0, 15)),
            NR'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART serial transmit line between NUM_REQ byte producers.
- Round-robin arbitration picks one pending requester per frame and latches its byte.
- Frames are serialized with an internal baud counter: 1 start bit, DATA_W data bits LSB first, 1 stop bit.
- Sits between on-chip byte sources (debug, status, console) and the board TX pin, replacing per-source transmitters.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data bits per frame
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  bit i: requester i has a byte pending
req_data  input  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept strobe, combinational
tx_out  output  1  serial line, idle high, registered
busy  output  1  frame in progress (state != IDLE), registered
grant_idx  output  clog2(NUM_REQ)  index of last accepted requester, registered

Behaviour:
- Reset, asynchronous: tx_out=1, busy=0, grant_idx=0, state=IDLE, bit counter=0, baud counter=0, rr pointer=0.
- A reset mid-frame aborts the frame immediately. The line returns high with no stop bit, and the byte is lost.
- Round-robin: the search starts at index ptr and wraps modulo NUM_REQ. The first i with req_valid[i]=1 wins. After an accept of i, ptr <= (i+1) mod NUM_REQ.
- req_ready[w]=1 only when state==IDLE, w is the winner, and req_valid[w]=1. Otherwise req_ready=0. At most one bit is ever set.
- Transfer occurs at the rising edge where req_valid[w] and req_ready[w] are both 1. On that edge: latch req_data slice, grant_idx<=w, busy<=1, state<=START, tx_out<=0, baud counter<=0.
- Requester rule: req_valid is held with stable data until accepted. Dropping an unaccepted req_valid is legal and simply removes it from arbitration.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx_out=shift[idx] for CLKS_PER_BIT cycles per bit, idx 0..DATA_W-1, then STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE with busy<=0.
- Baud counter counts 0..CLKS_PER_BIT-1. The bit advances on the terminal count. The counter restarts at 0 on every state entry.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles from the accept edge until busy falls.
- Back-to-back: the earliest next accept is in the first IDLE cycle. This guarantees exactly 1 cycle of idle-high between the stop bit and the next start bit.
- Requests arriving while busy wait. req_valid changes during a frame do not disturb the latched byte.
- Simultaneous requests: only the winner is accepted. The others stay pending and are served in rotation.
- A single requester issuing back-to-back bytes gets every frame when no one else requests.
- Counters are sized for CLKS_PER_BIT and DATA_W. No overflow or wrap occurs beyond the stated ranges.

Test Plan:
- Reset, then idle: tx_out=1, busy=0, req_ready=0 for 100 cycles. Assert rst mid-DATA: tx_out=1 and busy=0 the same cycle (async), ptr=0 after release.
- Req 2 sends 0xA5 (defaults): req_ready[2] high 1 cycle. Line shows 0 then 1,0,1,0,0,1,0,1 then 1, each 16 cycles. busy high 160 cycles, grant_idx=2.
- All 4 req_valid high from reset, each with data 0x10+i: accept order 0,1,2,3. Each frame is 160 cycles, separated by exactly 1 idle-high cycle.
- Req 1 and req 3 pending with ptr=2: 3 is granted first, then 1. Confirm ptr wraps from 3 to 0.
- Req 0 drops req_valid while req 1 is transmitting: req 0 is never granted and req_ready[0] stays 0. A later re-assert is served next.
- Change req_data of the granted requester during its frame: the serialized byte equals the value at the accept edge.
